// File: rtl/mult_test_sequencer_if.sv
// Bus between the MSDF multiplier test sequencer and its harness
// (operand RAMs, multiplier under test, golden RAM, result RAM, control).
//
// Strobe semantics: rd_en and wr_en are single-cycle qualifiers with no
// back-pressure. rd_addr is meaningful only while rd_en=1, and
// wr_addr/wr_data only while wr_en=1. Every data word is consumed in the
// cycle it is qualified; no ready signal exists anywhere on this bus.
interface mult_test_sequencer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int IN_WIDTH   = 93,
  parameter int OUT_WIDTH  = 189,
  parameter int CNT_WIDTH  = 16
);
  // control
  logic                  start;
  logic                  stop;
  logic [1:0]            mode;
  logic [ADDR_WIDTH:0]   num_tests;
  // operand RAM side
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [IN_WIDTH-1:0]   a_data;
  logic [IN_WIDTH-1:0]   b_data;
  // multiplier side
  logic [IN_WIDTH-1:0]   x_out;
  logic [IN_WIDTH-1:0]   y_out;
  logic [OUT_WIDTH-1:0]  p_in;
  // golden RAM side
  logic [ADDR_WIDTH-1:0] exp_rd_addr;
  logic [OUT_WIDTH-1:0]  exp_data;
  // result RAM side
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [OUT_WIDTH-1:0]  wr_data;
  // status
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  err_count;
  logic [CNT_WIDTH-1:0]  pass_count;
  logic [ADDR_WIDTH-1:0] first_fail_addr;
  logic                  fail_seen;
  // debug: current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
  logic [1:0]            dbg_state;

  modport master (
    input  start, stop, mode, num_tests, a_data, b_data, p_in, exp_data,
    output rd_en, rd_addr, x_out, y_out, exp_rd_addr, wr_en, wr_addr,
           wr_data, busy, done, err_count, pass_count, first_fail_addr,
           fail_seen, dbg_state
  );

  modport slave (
    output start, stop, mode, num_tests, a_data, b_data, p_in, exp_data,
    input  rd_en, rd_addr, x_out, y_out, exp_rd_addr, wr_en, wr_addr,
           wr_data, busy, done, err_count, pass_count, first_fail_addr,
           fail_seen, dbg_state
  );
endinterface

// File: rtl/mult_test_sequencer.sv
// Test sequencer for the MSDF multiplier harness: issues operand reads,
// registers multiplier inputs, carries each address down a delay line that
// matches the RAM + multiplier latency, writes products back at the matching
// address and optionally compares them against a golden RAM.
module mult_test_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int IN_WIDTH   = 93,
  parameter int OUT_WIDTH  = 189,
  parameter int LATENCY    = 18,
  parameter int RD_LAT     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input logic                   pll_clock,
  input logic                   reset,
  mult_test_sequencer_if.master bus
);

  // Issue at cycle t sits in stage k during cycle t+1+k.
  localparam int TOTAL   = RD_LAT + LATENCY + 2;
  localparam int EXP_TAP = LATENCY;     // presents golden address at t+LATENCY+1
  localparam int CMP_TAP = TOTAL - 2;   // cycle in which p_in for the entry is registered

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0]  IDX_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic                  start_q;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH:0]   n_q;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  pass_q;
  logic [CNT_WIDTH-1:0]  err_q;
  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] ffa_q;
  logic [IN_WIDTH-1:0]   x_q, y_q;
  logic [OUT_WIDTH-1:0]  wd_q;
  logic [TOTAL-1:0]      v_q;
  logic [ADDR_WIDTH-1:0] a_q [TOTAL];

  logic issue, accept, pass_end, last_idx, mismatch;

  // The index is one bit wider than the address so num_tests=2^ADDR_WIDTH
  // ends the pass without aliasing onto index 0.
  assign last_idx = ((idx_q + IDX_ONE) == n_q);
  assign mismatch = v_q[CMP_TAP] && (mode_q == 2'd2) && (bus.p_in != bus.exp_data);

  // Next-state logic: start-edge acceptance, issue stepping, loop wrap, drain detect.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    issue    = 1'b0;
    accept   = 1'b0;
    pass_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !start_q) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = (bus.num_tests == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (last_idx) begin
          pass_end = 1'b1;
          idx_d    = '0;
          if (!((mode_q == 2'd1) && !bus.stop)) state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_DRAIN: begin
        // The final entry is in the last stage and nothing follows it.
        if (v_q[TOTAL-1] && (v_q[TOTAL-2:0] == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, run latches, pass/error counters and first-fail capture.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      mode_q  <= 2'd0;
      n_q     <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      ffa_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      idx_q   <= idx_d;
      if (accept) begin
        mode_q <= bus.mode;
        n_q    <= bus.num_tests;
        pass_q <= '0;
        err_q  <= '0;
        fail_q <= 1'b0;
        ffa_q  <= '0;
      end else begin
        if (pass_end) pass_q <= pass_q + CNT_ONE;
        if (mismatch) begin
          if (err_q != '1) err_q <= err_q + CNT_ONE;
          if (!fail_q) begin
            fail_q <= 1'b1;
            ffa_q  <= a_q[CMP_TAP];
          end
        end
      end
    end
  end

  // Address delay line; reset clears valid bits so a mid-run reset stops all writes.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < TOTAL; i++) a_q[i] <= '0;
    end else begin
      v_q    <= {v_q[TOTAL-2:0], issue};
      a_q[0] <= issue ? idx_q[ADDR_WIDTH-1:0] : '0;
      for (int i = 1; i < TOTAL; i++) a_q[i] <= a_q[i-1];
    end
  end

  // Free-running data path: multiplier input stage and result write register.
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      wd_q <= '0;
    end else begin
      x_q  <= bus.a_data;
      y_q  <= bus.b_data;
      wd_q <= bus.p_in;
    end
  end

  assign bus.rd_en           = (state_q == S_RUN);
  assign bus.rd_addr         = idx_q[ADDR_WIDTH-1:0];
  assign bus.x_out           = x_q;
  assign bus.y_out           = y_q;
  assign bus.exp_rd_addr     = a_q[EXP_TAP];
  assign bus.wr_en           = v_q[TOTAL-1];
  assign bus.wr_addr         = a_q[TOTAL-1];
  assign bus.wr_data         = wd_q;
  assign bus.busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done            = (state_q == S_DONE);
  assign bus.err_count       = err_q;
  assign bus.pass_count      = pass_q;
  assign bus.first_fail_addr = ffa_q;
  assign bus.fail_seen       = fail_q;
  assign bus.dbg_state       = state_q;

endmodule
